vga_bounce_box: RTL

Pixel-generation stage that sits directly downstream of the 640x480 VGA timing generator. Consumes its horizontal/vertical counters, `vidon` and sync pulses, and produces registered 8-bit RGB (3-3-2) plus sync outputs delayed to match. Draws a solid square on a background colour and moves it once per frame, bouncing off the edges of the visible area. Serves as a self-contained display test pattern and as the template for later sprite stages.

---
 rtl/vga_bounce_box_if.sv | 10 +
 rtl/vga_bounce_box.sv | 100 ++++++++++
 2 files changed

// File: rtl/vga_bounce_box_if.sv
// vga_bounce_box_if: timing-generator bus (counters, visible flag, syncs) feeding pixel stages.
interface vga_bounce_box_if;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       vidon;
  logic       hsync;
  logic       vsync;
  modport master (output hc, vc, vidon, hsync, vsync);
  modport slave (input hc, vc, vidon, hsync, vsync);
endinterface

// File: rtl/vga_bounce_box.sv
// vga_bounce_box: draws a bouncing square over a background, registered RGB332 plus delayed syncs.
// Define VGA_BOX_COLOR_CYCLE_EN to step the box colour through a palette on every bounce.
module vga_bounce_box #(
  parameter int HBP = 144,
  parameter int VBP = 31,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32,
  parameter int SPEED = 2,
  parameter int X0 = 100,
  parameter int Y0 = 60,
  parameter logic [7:0] BOX_COLOR = 8'hE0,
  parameter logic [7:0] BG_COLOR = 8'h03
) (
  input  logic              clk,
  input  logic              clr_n,
  vga_bounce_box_if.slave   tg,
  input  logic              run,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              frame_tick
);
  localparam logic [10:0] BOX = 11'(BOX_SIZE);
  localparam logic [10:0] SP = 11'(SPEED);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [9:0] STEP = 10'(SPEED);
  logic [9:0] x, y;
  logic [9:0] bx_q, bx_d, by_q, by_d;
  logic       xdn_q, xdn_d, ydn_q, ydn_d;
  logic       vs_q, hs_o_q, vs_o_q, ft_q, ft_d;
  logic [7:0] rgb_q, rgb_d, box_c;
  logic       tick, step, bnx, bny, in_box;
  assign x = tg.hc - 10'(HBP);
  assign y = tg.vc - 10'(VBP);
  // xdn/ydn set means the box is moving towards 0 on that axis
  always_comb begin
    tick = vs_q & ~tg.vsync;
    step = tick & run;
    ft_d = tick;
    bnx = xdn_q ? ({1'b0, bx_q} <= SP) : ({1'b0, bx_q} + BOX + SP >= HA);
    bny = ydn_q ? ({1'b0, by_q} <= SP) : ({1'b0, by_q} + BOX + SP >= VA);
    bx_d = bx_q;
    by_d = by_q;
    xdn_d = xdn_q;
    ydn_d = ydn_q;
    if (step) begin
      bx_d = bnx ? (xdn_q ? '0 : 10'(H_ACTIVE - BOX_SIZE)) : (xdn_q ? bx_q - STEP : bx_q + STEP);
      by_d = bny ? (ydn_q ? '0 : 10'(V_ACTIVE - BOX_SIZE)) : (ydn_q ? by_q - STEP : by_q + STEP);
      xdn_d = xdn_q ^ bnx;
      ydn_d = ydn_q ^ bny;
    end
    in_box = ({1'b0, x} >= {1'b0, bx_q}) && ({1'b0, x} < {1'b0, bx_q} + BOX) &&
             ({1'b0, y} >= {1'b0, by_q}) && ({1'b0, y} < {1'b0, by_q} + BOX);
    rgb_d = !tg.vidon ? 8'h00 : in_box ? box_c : BG_COLOR;
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bx_q <= 10'(X0);
      by_q <= 10'(Y0);
      xdn_q <= 1'b0;
      ydn_q <= 1'b0;
      vs_q <= 1'b0;
      hs_o_q <= 1'b0;
      vs_o_q <= 1'b0;
      ft_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
      xdn_q <= xdn_d;
      ydn_q <= ydn_d;
      vs_q <= tg.vsync;
      hs_o_q <= tg.hsync;
      vs_o_q <= tg.vsync;
      ft_q <= ft_d;
      rgb_q <= rgb_d;
    end
  end
`ifdef VGA_BOX_COLOR_CYCLE_EN
  localparam logic [7:0] PAL [8] = '{8'hE0, 8'hFC, 8'h1C, 8'h1F, 8'h03, 8'hE3, 8'hFF, 8'h92};
  logic [2:0] ci_q, ci_d;
  // a corner hit is one bounce event, so both axes share one increment
  always_comb ci_d = (step && (bnx || bny)) ? ci_q + 3'd1 : ci_q;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) ci_q <= '0;
    else ci_q <= ci_d;
  end
  assign box_c = PAL[ci_q];
`else
  assign box_c = BOX_COLOR;
`endif
  assign {red, green, blue} = rgb_q;
  assign hsync_o = hs_o_q;
  assign vsync_o = vs_o_q;
  assign frame_tick = ft_q;
endmodule
